int_entry_seq: RTL and testbench
================================

Name: int_entry_seq

Overview:
- Interrupt-entry sequencer for the multi-cycle ARM-subset CPU: the entry half of the interrupt protocol whose exit half is the MOVS PC,LR return path in the main control FSM.
- Synchronises the IRQ/FIQ request lines and masks them with the CPSR I/F bits.
- At an instruction boundary it takes over the datapath for a fixed 4-state sequence: save CPSR to the banked SPSR, write LR, load the vector into PC, switch mode/mask, then acknowledge.
- Sits beside the main control FSM; its strobes are OR-ed into the datapath controls while hold_fetch is high.

Parameters:
- IRQ_VECTOR, 32'h00000018, PC value loaded on IRQ entry.
- FIQ_VECTOR, 32'h0000001C, PC value loaded on FIQ entry.
- IRQ_MODE, 5'b10010, CPSR mode field for IRQ.
- FIQ_MODE, 5'b10001, CPSR mode field for FIQ.
- SYNC_STAGES, 2, flip-flop depth of each request synchroniser (minimum 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  1  level interrupt request, asynchronous to clk.
- fiq  in  1  level fast interrupt request, asynchronous to clk.
- cpsr_i  in  1  CPSR I bit; 1 masks IRQ.
- cpsr_f  in  1  CPSR F bit; 1 masks FIQ.
- inst_boundary  in  1  one-cycle pulse from the main FSM in the last state of every instruction.
- hold_fetch  out  1  main FSM must not enter fetch (S0) while high.
- int_pending  out  1  a synchronised, unmasked request exists.
- write_spsr  out  1  SPSR write strobe.
- spsr_bank  out  1  0 = IRQ SPSR, 1 = FIQ SPSR.
- write_reg  out  1  register-file write strobe.
- reg_addr  out  4  register-file write address.
- w_rdata_s  out  2  register write-data select; 2'b10 = current PC.
- write_pc  out  1  PC write strobe.
- pc_s  out  3  PC source select; 3'b010 = vector bus.
- vector  out  32  vector value for the PC mux.
- write_cpsr  out  1  CPSR write strobe.
- w_cpsr_s  out  3  CPSR source select; 3'b010 = mode/mask update.
- new_mode  out  5  mode field written with write_cpsr.
- set_i  out  1  force I=1 on the CPSR write.
- set_f  out  1  force F=1 on the CPSR write.
- irq_ack  out  1  one-cycle IRQ acknowledge.
- fiq_ack  out  1  one-cycle FIQ acknowledge.

Behaviour:
- Synchronisers:
  - irq and fiq each pass through SYNC_STAGES flops; the outputs are irq_s and fiq_s.
  - int_pending = (fiq_s & ~cpsr_f) | (irq_s & ~cpsr_i); combinational from synchronised values.
- Reset (async): state = IDLE, synchroniser flops = 0, sel (latched source) = 0, vector = 0. Every other output is 0.
- States: IDLE, SAVE, LINK, VEC, ACK. Outputs are Moore, decoded from the current state only.
- IDLE:
  - Transition: if inst_boundary & int_pending, go to SAVE and latch sel = fiq_s & ~cpsr_f. FIQ wins when both are valid.
  - On the same edge, latch vector = sel ? FIQ_VECTOR : IRQ_VECTOR. vector holds this value until the next accept.
  - Otherwise stay in IDLE. A request without a boundary is ignored until a boundary arrives.
- SAVE: hold_fetch=1, write_spsr=1, spsr_bank=sel. Next state: LINK.
- LINK: hold_fetch=1, write_reg=1, reg_addr=4'd14, w_rdata_s=2'b10. LR is written with the already-incremented PC, so MOVS PC,LR returns to the next instruction. Next state: VEC.
- VEC:
  - Strobes: hold_fetch=1, write_pc=1, pc_s=3'b010, write_cpsr=1, w_cpsr_s=3'b010.
  - Mode/mask: new_mode = sel ? FIQ_MODE : IRQ_MODE, set_i=1, set_f=sel.
  - Next state: ACK.
- ACK: hold_fetch=1, irq_ack=~sel, fiq_ack=sel. Next state: IDLE. hold_fetch drops in the following cycle and the main FSM fetches from the vector.
- Timing:
  - Accept edge N → SAVE at N+1, LINK at N+2, VEC at N+3, ACK at N+4, IDLE at N+5.
  - Each strobe is exactly 1 cycle wide.
- Boundary conditions:
  - Once accepted, the sequence runs to completion. Request deassertion or mask changes mid-sequence have no effect, and sel is frozen.
  - inst_boundary outside IDLE is ignored. The main FSM never issues it while hold_fetch=1.
  - A request that is masked at the boundary is not taken. A level request stays pending and is taken at the first boundary after unmasking.
  - FIQ arriving during an IRQ entry is taken at the first handler-instruction boundary, because F is still 0 after IRQ entry.
  - IRQ arriving during a FIQ entry is not taken until return, because I=1.
  - rst asserted mid-sequence aborts immediately to IDLE with all strobes 0. No partial ack is issued.
  - Request pulses shorter than SYNC_STAGES+1 clocks may be missed; sources must hold the level until acknowledged.

Test Plan:
- irq=1, cpsr_i=0, boundary pulse at cycle 10 → write_spsr at 11 (bank 0), write_reg at 12 (addr 14, w_rdata_s=2), write_pc at 13 with vector=32'h18, new_mode=5'b10010, set_i=1, set_f=0, irq_ack at 14, hold_fetch 11–14.
- irq=fiq=1, both unmasked, boundary pulse → spsr_bank=1, vector=32'h1C, new_mode=5'b10001, set_f=1, fiq_ack only.
- irq=1, cpsr_i=1, 3 boundaries → no strobes, int_pending=0. Clear cpsr_i → entry begins on the next boundary.
- Entry accepted, then irq dropped at SAVE → LINK/VEC/ACK still issued with unchanged values.
- rst asserted during LINK → all outputs 0 immediately, state IDLE, no irq_ack. After release with irq still high, entry restarts at the next boundary.
- IRQ entry completes, fiq raised at VEC → FIQ taken at the next boundary, with fiq_ack 4 cycles after that boundary.

Source files
------------

// File: rtl/int_entry_seq.sv
// -----------------------------------------------------------------------------
// int_entry_seq
//
// Interrupt-entry sequencer for the multi-cycle ARM-subset CPU. It synchronises
// the IRQ/FIQ request lines and masks them with the CPSR I/F bits. At an
// instruction boundary it takes over the datapath for four cycles:
//   SAVE : CPSR -> banked SPSR
//   LINK : current (already incremented) PC -> LR (r14)
//   VEC  : vector -> PC, new mode and mask bits -> CPSR
//   ACK  : one-cycle acknowledge to the winning source
// The return half of the protocol (MOVS PC,LR) lives in the main control FSM.
// The strobes below are OR-ed into the datapath controls while hold_fetch is 1.
//
// Ports
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   irq, fiq       : level requests, asynchronous to clk
//   cpsr_i, cpsr_f : CPSR mask bits (1 = masked)
//   inst_boundary  : one-cycle pulse in the last state of every instruction
//   hold_fetch     : keeps the main FSM out of fetch during the sequence
//   int_pending    : a synchronised, unmasked request exists
//   write_spsr, spsr_bank              : SPSR write strobe and bank (1 = FIQ)
//   write_reg, reg_addr, w_rdata_s     : register-file write of LR
//   write_pc, pc_s, vector             : PC load from the vector bus
//   write_cpsr, w_cpsr_s, new_mode,
//   set_i, set_f                       : CPSR mode/mask update
//   irq_ack, fiq_ack                   : one-cycle acknowledges
// -----------------------------------------------------------------------------
module int_entry_seq #(
    parameter logic [31:0] IRQ_VECTOR  = 32'h0000_0018,
    parameter logic [31:0] FIQ_VECTOR  = 32'h0000_001C,
    parameter logic [4:0]  IRQ_MODE    = 5'b10010,
    parameter logic [4:0]  FIQ_MODE    = 5'b10001,
    parameter int          SYNC_STAGES = 2              // must be >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irq,
    input  logic        fiq,
    input  logic        cpsr_i,
    input  logic        cpsr_f,
    input  logic        inst_boundary,
    output logic        hold_fetch,
    output logic        int_pending,
    output logic        write_spsr,
    output logic        spsr_bank,
    output logic        write_reg,
    output logic [3:0]  reg_addr,
    output logic [1:0]  w_rdata_s,
    output logic        write_pc,
    output logic [2:0]  pc_s,
    output logic [31:0] vector,
    output logic        write_cpsr,
    output logic [2:0]  w_cpsr_s,
    output logic [4:0]  new_mode,
    output logic        set_i,
    output logic        set_f,
    output logic        irq_ack,
    output logic        fiq_ack
);

    localparam logic [3:0] LR_ADDR      = 4'd14;
    localparam logic [1:0] WDATA_PC     = 2'b10;
    localparam logic [2:0] PC_SRC_VEC   = 3'b010;
    localparam logic [2:0] CPSR_SRC_MOD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_LINK = 3'd2,
        ST_VEC  = 3'd3,
        ST_ACK  = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_sel;          // latched source: 1 = FIQ
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic [SYNC_STAGES-1:0] r_fiq_sync;

    logic w_irq_s;
    logic w_fiq_s;
    logic w_fiq_valid;
    logic w_irq_valid;
    logic w_pending;
    logic w_accept;

    // Request synchronisers: shift the raw level in at the LSB, use the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_sync <= '0;
            r_fiq_sync <= '0;
        end else begin
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq};
            r_fiq_sync <= {r_fiq_sync[SYNC_STAGES-2:0], fiq};
        end
    end

    assign w_irq_s     = r_irq_sync[SYNC_STAGES-1];
    assign w_fiq_s     = r_fiq_sync[SYNC_STAGES-1];
    assign w_fiq_valid = w_fiq_s & ~cpsr_f;
    assign w_irq_valid = w_irq_s & ~cpsr_i;
    assign w_pending   = w_fiq_valid | w_irq_valid;
    assign int_pending = w_pending;

    // The main FSM never pulses inst_boundary while hold_fetch is high, and
    // outside IDLE the pulse is ignored anyway.
    assign w_accept    = inst_boundary & w_pending;

    // Sequencer. Outputs are registered: each branch loads the strobes that
    // belong to the state being entered, so they line up with that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            vector     <= 32'h0000_0000;
            hold_fetch <= 1'b0;
            write_spsr <= 1'b0;
            spsr_bank  <= 1'b0;
            write_reg  <= 1'b0;
            reg_addr   <= 4'd0;
            w_rdata_s  <= 2'b00;
            write_pc   <= 1'b0;
            pc_s       <= 3'b000;
            write_cpsr <= 1'b0;
            w_cpsr_s   <= 3'b000;
            new_mode   <= 5'b00000;
            set_i      <= 1'b0;
            set_f      <= 1'b0;
            irq_ack    <= 1'b0;
            fiq_ack    <= 1'b0;
        end else begin
            // Every strobe is one cycle wide unless the next state sets it.
            hold_fetch <= 1'b0;
            write_spsr <= 1'b0;
            spsr_bank  <= 1'b0;
            write_reg  <= 1'b0;
            reg_addr   <= 4'd0;
            w_rdata_s  <= 2'b00;
            write_pc   <= 1'b0;
            pc_s       <= 3'b000;
            write_cpsr <= 1'b0;
            w_cpsr_s   <= 3'b000;
            new_mode   <= 5'b00000;
            set_i      <= 1'b0;
            set_f      <= 1'b0;
            irq_ack    <= 1'b0;
            fiq_ack    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // FIQ wins when both sources are valid. sel and the
                        // vector stay frozen until the next accept.
                        r_state    <= ST_SAVE;
                        r_sel      <= w_fiq_valid;
                        vector     <= w_fiq_valid ? FIQ_VECTOR : IRQ_VECTOR;
                        hold_fetch <= 1'b1;
                        write_spsr <= 1'b1;
                        spsr_bank  <= w_fiq_valid;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SAVE: begin
                    // LR gets the already-incremented PC so MOVS PC,LR
                    // resumes at the next instruction.
                    r_state    <= ST_LINK;
                    hold_fetch <= 1'b1;
                    write_reg  <= 1'b1;
                    reg_addr   <= LR_ADDR;
                    w_rdata_s  <= WDATA_PC;
                end
                ST_LINK: begin
                    r_state    <= ST_VEC;
                    hold_fetch <= 1'b1;
                    write_pc   <= 1'b1;
                    pc_s       <= PC_SRC_VEC;
                    write_cpsr <= 1'b1;
                    w_cpsr_s   <= CPSR_SRC_MOD;
                    new_mode   <= r_sel ? FIQ_MODE : IRQ_MODE;
                    set_i      <= 1'b1;
                    set_f      <= r_sel;
                end
                ST_VEC: begin
                    r_state    <= ST_ACK;
                    hold_fetch <= 1'b1;
                    irq_ack    <= ~r_sel;
                    fiq_ack    <= r_sel;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_entry_seq.sv
// -----------------------------------------------------------------------------
// tb_int_entry_seq
//
// Directed, table-driven bench for int_entry_seq. Each table row is one clock:
// inputs are driven on the falling edge, outputs are sampled 1 time unit after
// the rising edge and compared with values built from the expected phase,
// latched source, pending flag and vector of that row.
// -----------------------------------------------------------------------------
module tb_int_entry_seq;

    localparam int P_IDLE = 0;
    localparam int P_SAVE = 1;
    localparam int P_LINK = 2;
    localparam int P_VEC  = 3;
    localparam int P_ACK  = 4;

    localparam logic [31:0] V0 = 32'h0000_0000;
    localparam logic [31:0] VI = 32'h0000_0018;
    localparam logic [31:0] VF = 32'h0000_001C;

    typedef struct {
        logic        irq;
        logic        fiq;
        logic        ci;
        logic        cf;
        logic        bnd;
        int          ph;
        logic        sel;
        logic        pend;
        logic [31:0] vec;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq, fiq, cpsr_i, cpsr_f, inst_boundary;
    logic        hold_fetch, int_pending, write_spsr, spsr_bank, write_reg;
    logic [3:0]  reg_addr;
    logic [1:0]  w_rdata_s;
    logic        write_pc;
    logic [2:0]  pc_s;
    logic [31:0] vector;
    logic        write_cpsr;
    logic [2:0]  w_cpsr_s;
    logic [4:0]  new_mode;
    logic        set_i, set_f, irq_ack, fiq_ack;
    logic [59:0] act;

    int n_tests = 0;
    int n_fail  = 0;
    rec_t tbl[$];

    int_entry_seq dut (
        .clk(clk), .rst(rst), .irq(irq), .fiq(fiq),
        .cpsr_i(cpsr_i), .cpsr_f(cpsr_f), .inst_boundary(inst_boundary),
        .hold_fetch(hold_fetch), .int_pending(int_pending),
        .write_spsr(write_spsr), .spsr_bank(spsr_bank),
        .write_reg(write_reg), .reg_addr(reg_addr), .w_rdata_s(w_rdata_s),
        .write_pc(write_pc), .pc_s(pc_s), .vector(vector),
        .write_cpsr(write_cpsr), .w_cpsr_s(w_cpsr_s), .new_mode(new_mode),
        .set_i(set_i), .set_f(set_f), .irq_ack(irq_ack), .fiq_ack(fiq_ack)
    );

    always #5 clk = ~clk;

    assign act = {hold_fetch, int_pending, write_spsr, spsr_bank, write_reg,
                  reg_addr, w_rdata_s, write_pc, pc_s, vector, write_cpsr,
                  w_cpsr_s, new_mode, set_i, set_f, irq_ack, fiq_ack};

    function automatic rec_t mk(logic i, logic f, logic ci, logic cf, logic b,
                                int ph, logic sel, logic pend, logic [31:0] vec);
        rec_t r;
        r.irq = i;  r.fiq = f;  r.ci = ci;  r.cf = cf;  r.bnd = b;
        r.ph = ph;  r.sel = sel;  r.pend = pend;  r.vec = vec;
        return r;
    endfunction

    // Expected outputs for a given phase, written straight from the protocol.
    function automatic logic [59:0] model(int ph, logic sel, logic pend, logic [31:0] vec);
        logic       hold, wsp, bank, wreg, wpc, wcp, si, sf, ia, fa;
        logic [3:0] addr;
        logic [1:0] wrd;
        logic [2:0] pcs, cps;
        logic [4:0] mode;
        hold = 1'b0; wsp = 1'b0; bank = 1'b0; wreg = 1'b0; wpc = 1'b0;
        wcp = 1'b0; si = 1'b0; sf = 1'b0; ia = 1'b0; fa = 1'b0;
        addr = 4'd0; wrd = 2'd0; pcs = 3'd0; cps = 3'd0; mode = 5'd0;
        case (ph)
            P_SAVE: begin hold = 1'b1; wsp = 1'b1; bank = sel; end
            P_LINK: begin hold = 1'b1; wreg = 1'b1; addr = 4'd14; wrd = 2'b10; end
            P_VEC: begin
                hold = 1'b1; wpc = 1'b1; pcs = 3'b010; wcp = 1'b1; cps = 3'b010;
                mode = sel ? 5'b10001 : 5'b10010; si = 1'b1; sf = sel;
            end
            P_ACK: begin hold = 1'b1; ia = ~sel; fa = sel; end
            default: ;
        endcase
        return {hold, pend, wsp, bank, wreg, addr, wrd, wpc, pcs, vec, wcp,
                cps, mode, si, sf, ia, fa};
    endfunction

    task automatic check(input string name, input logic [59:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input rec_t r, input string name);
        @(negedge clk);
        irq = r.irq;  fiq = r.fiq;  cpsr_i = r.ci;  cpsr_f = r.cf;
        inst_boundary = r.bnd;
        @(posedge clk);
        #1;
        check(name, model(r.ph, r.sel, r.pend, r.vec));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq = 1'b0; fiq = 1'b0; cpsr_i = 1'b0; cpsr_f = 1'b0;
        inst_boundary = 1'b0;

        //            irq fiq ci cf bnd  phase   sel pend vec
        // basic IRQ entry
        tbl.push_back(mk(1, 0, 0, 0, 0, P_IDLE, 0, 0, V0));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_IDLE, 0, 1, V0));
        tbl.push_back(mk(1, 0, 0, 0, 1, P_SAVE, 0, 1, VI));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_LINK, 0, 1, VI));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_VEC,  0, 1, VI));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_ACK,  0, 1, VI));
        tbl.push_back(mk(0, 0, 1, 0, 0, P_IDLE, 0, 0, VI));
        tbl.push_back(mk(0, 0, 1, 0, 0, P_IDLE, 0, 0, VI));
        // IRQ and FIQ together: FIQ wins
        tbl.push_back(mk(1, 1, 0, 0, 0, P_IDLE, 0, 0, VI));
        tbl.push_back(mk(1, 1, 0, 0, 0, P_IDLE, 0, 1, VI));
        tbl.push_back(mk(1, 1, 0, 0, 1, P_SAVE, 1, 1, VF));
        tbl.push_back(mk(1, 1, 0, 0, 0, P_LINK, 1, 1, VF));
        tbl.push_back(mk(1, 1, 0, 0, 0, P_VEC,  1, 1, VF));
        tbl.push_back(mk(1, 1, 0, 0, 0, P_ACK,  1, 1, VF));
        tbl.push_back(mk(0, 0, 1, 1, 0, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(0, 0, 0, 0, 0, P_IDLE, 0, 0, VF));
        // masked IRQ ignored over three boundaries, then taken after unmask;
        // irq drops at SAVE and the sequence still completes
        tbl.push_back(mk(1, 0, 1, 0, 0, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(1, 0, 1, 0, 0, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(1, 0, 1, 0, 1, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(1, 0, 1, 0, 0, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(1, 0, 1, 0, 1, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(1, 0, 1, 0, 1, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_IDLE, 0, 1, VF));
        tbl.push_back(mk(1, 0, 0, 0, 1, P_SAVE, 0, 1, VI));
        tbl.push_back(mk(0, 0, 0, 0, 0, P_LINK, 0, 1, VI));
        tbl.push_back(mk(0, 0, 0, 0, 0, P_VEC,  0, 0, VI));
        tbl.push_back(mk(0, 0, 0, 0, 0, P_ACK,  0, 0, VI));
        tbl.push_back(mk(0, 0, 0, 0, 0, P_IDLE, 0, 0, VI));
        // IRQ entry; FIQ raised and I set at VEC; FIQ taken at next boundary.
        // Boundaries during SAVE/LINK of the FIQ entry are ignored.
        tbl.push_back(mk(1, 0, 0, 0, 0, P_IDLE, 0, 0, VI));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_IDLE, 0, 1, VI));
        tbl.push_back(mk(1, 0, 0, 0, 1, P_SAVE, 0, 1, VI));
        tbl.push_back(mk(1, 0, 0, 0, 0, P_LINK, 0, 1, VI));
        tbl.push_back(mk(1, 1, 1, 0, 0, P_VEC,  0, 0, VI));
        tbl.push_back(mk(1, 1, 1, 0, 0, P_ACK,  0, 1, VI));
        tbl.push_back(mk(1, 1, 1, 0, 0, P_IDLE, 0, 1, VI));
        tbl.push_back(mk(1, 1, 1, 0, 1, P_SAVE, 1, 1, VF));
        tbl.push_back(mk(1, 1, 1, 0, 1, P_LINK, 1, 1, VF));
        tbl.push_back(mk(1, 1, 1, 0, 1, P_VEC,  1, 1, VF));
        tbl.push_back(mk(1, 1, 1, 0, 0, P_ACK,  1, 1, VF));
        tbl.push_back(mk(0, 0, 1, 1, 0, P_IDLE, 0, 0, VF));
        tbl.push_back(mk(0, 0, 0, 0, 0, P_IDLE, 0, 0, VF));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", model(P_IDLE, 1'b0, 1'b0, V0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // reset asserted during LINK aborts the sequence with no ack
        apply(mk(1, 0, 0, 0, 0, P_IDLE, 0, 0, VF), "rs_sync0");
        apply(mk(1, 0, 0, 0, 0, P_IDLE, 0, 1, VF), "rs_sync1");
        apply(mk(1, 0, 0, 0, 1, P_SAVE, 0, 1, VI), "rs_save");
        apply(mk(1, 0, 0, 0, 0, P_LINK, 0, 1, VI), "rs_link");
        #2;
        rst = 1'b1;
        #1;
        check("rs_abort", model(P_IDLE, 1'b0, 1'b0, V0));
        @(negedge clk);
        rst = 1'b0;
        // one edge passes with irq high before the next row, so the
        // synchroniser is full again after this row
        apply(mk(1, 0, 0, 0, 0, P_IDLE, 0, 1, V0), "rs_resync");
        apply(mk(1, 0, 0, 0, 1, P_SAVE, 0, 1, VI), "rs_resave");
        apply(mk(1, 0, 0, 0, 0, P_LINK, 0, 1, VI), "rs_relink");
        apply(mk(1, 0, 0, 0, 0, P_VEC,  0, 1, VI), "rs_revec");
        apply(mk(1, 0, 0, 0, 0, P_ACK,  0, 1, VI), "rs_reack");
        apply(mk(0, 0, 1, 0, 0, P_IDLE, 0, 0, VI), "rs_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
